mem_lsu: RTL and testbench

- Memory-stage load/store unit of the core; sits directly upstream of the writeback merge.
- Takes one load or store per request from EX, runs a single-outstanding data-bus transaction, and formats load data.
- Returns load results on the writeback memory port (rd address + data) for exactly one cycle.
- Stalls EX while busy so that the EX writeback port never carries a nonzero rd in the same cycle as a load result.

---
 rtl/mem_lsu.sv | 215 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit. Accepts one load/store from EX,
// runs a single-outstanding data-bus transaction, and formats load data
// for the writeback merge port.
//   Ports: i_clk/i_rst_n; EX side i_valid, i_ld, i_st, i_funct3, i_addr,
//          i_wdata, i_rd_addr; o_busy (EX hold); writeback o_rd_addr,
//          o_rd_data; o_fault pulse; data bus o_bus_* / i_bus_*.
//   Latency: accept N -> req N+1; load writeback the cycle after rvalid
//            (minimum 3 cycles). Only o_busy is combinational.
module mem_lsu #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic        i_ld,
   input  logic        i_st,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [4:0]  i_rd_addr,
   output logic        o_busy,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd_data,
   output logic        o_fault,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_be,
   input  logic        i_bus_gnt,
   input  logic        i_bus_rvalid,
   input  logic [31:0] i_bus_rdata
);

   localparam logic [7:0] TMO_LIMIT = BUS_TIMEOUT[7:0];
   localparam bit         TMO_EN    = (BUS_TIMEOUT != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      state, state_n;
   logic [7:0]  cnt, cnt_n;
   logic        op_ld, op_ld_n;
   logic [1:0]  off, off_n;
   logic [2:0]  f3, f3_n;
   logic [4:0]  rd, rd_n;

   logic [4:0]  rd_addr_n;
   logic [31:0] rd_data_n;
   logic        fault_n;
   logic        bus_req_n;
   logic        bus_we_n;
   logic [31:0] bus_addr_n;
   logic [31:0] bus_wdata_n;
   logic [3:0]  bus_be_n;

   logic        dec_bad;
   logic        tmo_hit;
   logic [31:0] byte_sh;
   logic [31:0] half_sh;
   logic [31:0] ld_val;
   logic [3:0]  be_calc;

   assign o_busy = (state != S_IDLE);

   // Decode faults: conflicting op, illegal size, misalignment, and
   // stores carrying the zero-extend bit.
   always_comb begin
      dec_bad = 1'b0;
      if (i_ld && i_st)                                     dec_bad = 1'b1;
      if (i_funct3[1:0] == 2'b11)                           dec_bad = 1'b1;
      if (i_funct3[1:0] == 2'b01 && i_addr[0])              dec_bad = 1'b1;
      if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00)   dec_bad = 1'b1;
      if (i_st && i_funct3[2])                              dec_bad = 1'b1;
   end

   always_comb begin
      case (i_funct3[1:0])
         2'b00:   be_calc = 4'b0001 << i_addr[1:0];
         2'b01:   be_calc = i_addr[1] ? 4'b1100 : 4'b0011;
         default: be_calc = 4'b1111;
      endcase
   end

   // Lane extraction: shift the selected lane down to bit 0 then extend.
   assign byte_sh = i_bus_rdata >> {off, 3'b000};
   assign half_sh = i_bus_rdata >> {off[1], 4'b0000};

   always_comb begin
      case (f3[1:0])
         2'b00:   ld_val = f3[2] ? {24'd0, byte_sh[7:0]}
                                 : {{24{byte_sh[7]}}, byte_sh[7:0]};
         2'b01:   ld_val = f3[2] ? {16'd0, half_sh[15:0]}
                                 : {{16{half_sh[15]}}, half_sh[15:0]};
         default: ld_val = i_bus_rdata;
      endcase
   end

   assign tmo_hit = TMO_EN && (cnt == TMO_LIMIT);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      op_ld_n     = op_ld;
      off_n       = off;
      f3_n        = f3;
      rd_n        = rd;
      rd_addr_n   = 5'd0;
      rd_data_n   = 32'd0;
      fault_n     = 1'b0;
      bus_req_n   = o_bus_req;
      bus_we_n    = o_bus_we;
      bus_addr_n  = o_bus_addr;
      bus_wdata_n = o_bus_wdata;
      bus_be_n    = o_bus_be;

      case (state)
         S_IDLE: begin
            if (i_valid && (i_ld || i_st)) begin
               if (dec_bad) begin
                  fault_n = 1'b1;
               end else begin
                  state_n    = S_REQ;
                  cnt_n      = 8'd0;
                  op_ld_n    = i_ld;
                  off_n      = i_addr[1:0];
                  f3_n       = i_funct3;
                  rd_n       = i_rd_addr;
                  bus_req_n  = 1'b1;
                  bus_we_n   = i_st;
                  bus_addr_n = {i_addr[31:2], 2'b00};
                  bus_be_n   = be_calc;
                  if (!i_st)
                     bus_wdata_n = 32'd0;
                  else if (i_funct3[1:0] == 2'b00)
                     bus_wdata_n = {4{i_wdata[7:0]}};
                  else if (i_funct3[1:0] == 2'b01)
                     bus_wdata_n = {2{i_wdata[15:0]}};
                  else
                     bus_wdata_n = i_wdata;
               end
            end
         end
         S_REQ: begin
            // Timeout pre-empts a grant arriving in the same cycle.
            if (tmo_hit) begin
               state_n   = S_IDLE;
               bus_req_n = 1'b0;
               fault_n   = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
               if (i_bus_gnt) begin
                  bus_req_n = 1'b0;
                  state_n   = op_ld ? S_WAIT : S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (tmo_hit) begin
               state_n = S_IDLE;
               fault_n = 1'b1;
            end else begin
               cnt_n = cnt + 8'd1;
               if (i_bus_rvalid) begin
                  state_n   = S_IDLE;
                  rd_addr_n = rd;   // x0 load still completes, but rd stays 0
                  rd_data_n = ld_val;
               end
            end
         end
         default: begin
            state_n   = S_IDLE;
            bus_req_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         cnt         <= 8'd0;
         op_ld       <= 1'b0;
         off         <= 2'd0;
         f3          <= 3'd0;
         rd          <= 5'd0;
         o_rd_addr   <= 5'd0;
         o_rd_data   <= 32'd0;
         o_fault     <= 1'b0;
         o_bus_req   <= 1'b0;
         o_bus_we    <= 1'b0;
         o_bus_addr  <= 32'd0;
         o_bus_wdata <= 32'd0;
         o_bus_be    <= 4'd0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         op_ld       <= op_ld_n;
         off         <= off_n;
         f3          <= f3_n;
         rd          <= rd_n;
         o_rd_addr   <= rd_addr_n;
         o_rd_data   <= rd_data_n;
         o_fault     <= fault_n;
         o_bus_req   <= bus_req_n;
         o_bus_we    <= bus_we_n;
         o_bus_addr  <= bus_addr_n;
         o_bus_wdata <= bus_wdata_n;
         o_bus_be    <= bus_be_n;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed plus randomized checks of mem_lsu against a
// transaction-level model of bus timing, store lanes and load extension.
module tb_mem_lsu;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, ld = 1'b0, st = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        busy, fault, bus_req, bus_we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data, bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = 32'd0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_lsu #(.BUS_TIMEOUT(T)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_valid(valid), .i_ld(ld), .i_st(st), .i_funct3(funct3),
      .i_addr(addr), .i_wdata(wdata), .i_rd_addr(rd_in),
      .o_busy(busy), .o_rd_addr(rd_addr), .o_rd_data(rd_data), .o_fault(fault),
      .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
      .o_bus_wdata(bus_wdata), .o_bus_be(bus_be),
      .i_bus_gnt(gnt), .i_bus_rvalid(rvalid), .i_bus_rdata(rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit is_bad(bit l, bit s, logic [2:0] f, logic [31:0] a);
      if (l && s) return 1;
      if (f[1:0] == 2'd3) return 1;
      if (f[1:0] == 2'd1 && a[0]) return 1;
      if (f[1:0] == 2'd2 && a[1:0] != 2'd0) return 1;
      if (s && f[2]) return 1;
      return 0;
   endfunction

   function automatic logic [3:0] exp_be(logic [2:0] f, logic [31:0] a);
      int o = int'(a[1:0]);
      if (f[1:0] == 2'd0) return 4'(1 << o);
      if (f[1:0] == 2'd1) return (o >= 2) ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] exp_wd(logic [2:0] f, logic [31:0] w);
      logic [31:0] b = w & 32'hFF;
      logic [31:0] h = w & 32'hFFFF;
      if (f[1:0] == 2'd0) return b * 32'h01010101;
      if (f[1:0] == 2'd1) return h * 32'h00010001;
      return w;
   endfunction

   function automatic logic [31:0] exp_ld(logic [2:0] f, logic [31:0] a, logic [31:0] d);
      int o = int'(a[1:0]);
      logic [31:0] v;
      if (f[1:0] == 2'd0) begin
         v = (d / (32'd1 << (8 * o))) % 32'd256;
         if (!f[2] && v >= 32'd128) v = v + 32'hFFFFFF00;
      end else if (f[1:0] == 2'd1) begin
         v = (o >= 2) ? d / 32'h10000 : d % 32'h10000;
         if (!f[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   // Runs one op presented at cycle N. g = cycles after entering REQ until
   // grant; r = cycles in WAIT before rvalid.
   task automatic run_op(input bit l, input bit s, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [4:0] rdi, input int g, input int r,
                         input logic [31:0] d, input string nm);
      bit bad, tmo;
      int evt, fin, req_end;
      @(negedge clk);
      valid = 1; ld = l; st = s; funct3 = f; addr = a; wdata = w; rd_in = rdi;
      gnt = 0; rvalid = 0;
      bad = is_bad(l, s, f, a);
      @(negedge clk);
      if (bad) begin
         valid = 0;
         chk({nm, "_fault"}, 32'(fault), 1);
         chk({nm, "_fbusy"}, 32'(busy), 0);
         chk({nm, "_freq"}, 32'(bus_req), 0);
         @(negedge clk);
         chk({nm, "_fclr"}, 32'(fault), 0);
         chk({nm, "_fbusy2"}, 32'(busy), 0);
         return;
      end
      evt = l ? g + 1 + r : g;
      tmo = (evt > T);
      fin = tmo ? T : evt;
      req_end = (g < fin) ? g : fin;
      for (int k = 0; k <= fin; k++) begin
         if (k > 0) @(negedge clk);
         chk({nm, "_busy"}, 32'(busy), 1);
         chk({nm, "_req"}, 32'(bus_req), 32'(k <= req_end));
         chk({nm, "_nowb"}, 32'(rd_addr), 0);
         chk({nm, "_nof"}, 32'(fault), 0);
         if (k <= req_end) begin
            chk({nm, "_addr"}, bus_addr, {a[31:2], 2'b00});
            chk({nm, "_we"}, 32'(bus_we), 32'(s));
            if (s) begin
               chk({nm, "_be"}, 32'(bus_be), 32'(exp_be(f, a)));
               chk({nm, "_wd"}, bus_wdata, exp_wd(f, w));
            end
         end
         // While busy, EX inputs are junk and must be ignored.
         valid = 1'($urandom); ld = 1'($urandom); st = 1'($urandom);
         addr = $urandom; funct3 = 3'($urandom);
         gnt = (k == g);
         if (l && k == evt) begin
            rvalid = 1; rdata = d;
         end else begin
            rvalid = (k <= g) ? 1'($urandom) : 1'b0;
            rdata = $urandom;
         end
      end
      @(negedge clk);
      valid = 0; gnt = 0; rvalid = 0; ld = 0; st = 0;
      chk({nm, "_idle"}, 32'(busy), 0);
      chk({nm, "_reqoff"}, 32'(bus_req), 0);
      chk({nm, "_tmo"}, 32'(fault), 32'(tmo));
      chk({nm, "_wbrd"}, 32'(rd_addr), (l && !tmo) ? 32'(rdi) : 32'd0);
      if (l && !tmo && rdi != 0) chk({nm, "_wbd"}, rd_data, exp_ld(f, a, d));
      @(negedge clk);
      chk({nm, "_wbone"}, 32'(rd_addr), 0);
      chk({nm, "_fone"}, 32'(fault), 0);
   endtask

   initial begin
      #100000000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      bit l, s;
      logic [2:0] f;
      logic [31:0] a;
      int g, r, kind;

      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rd", 32'(rd_addr), 0);
      chk("rst_rdd", rd_data, 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_req", 32'(bus_req), 0);
      chk("rst_we", 32'(bus_we), 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_wd", bus_wdata, 0);
      chk("rst_be", 32'(bus_be), 0);
      @(negedge clk); rst_n = 1;

      // valid without ld/st is ignored
      @(negedge clk); valid = 1; ld = 0; st = 0;
      @(negedge clk); valid = 0;
      chk("nop_busy", 32'(busy), 0);
      chk("nop_req", 32'(bus_req), 0);
      chk("nop_fault", 32'(fault), 0);

      run_op(0, 1, 3'b010, 32'h104,  32'hDEADBEEF, 5'd0, 2, 0, 0, "sw");
      run_op(0, 1, 3'b000, 32'h1003, 32'h000000A5, 5'd0, 0, 0, 0, "sb");
      run_op(0, 1, 3'b001, 32'h1002, 32'h1234CAFE, 5'd0, 1, 0, 0, "sh");
      run_op(1, 0, 3'b000, 32'h202, 0, 5'd5, 0, 0, 32'h12F03456, "lb");
      run_op(1, 0, 3'b100, 32'h202, 0, 5'd5, 1, 1, 32'h12F03456, "lbu");
      run_op(1, 0, 3'b001, 32'h202, 0, 5'd5, 0, 1, 32'h12F03456, "lh");
      run_op(1, 0, 3'b010, 32'h101, 0, 5'd5, 0, 0, 0, "lwmis");
      run_op(1, 1, 3'b010, 32'h100, 0, 5'd5, 0, 0, 0, "ldst");
      run_op(1, 0, 3'b011, 32'h100, 0, 5'd5, 0, 0, 0, "sz11");
      run_op(1, 0, 3'b010, 32'h300, 0, 5'd0, 0, 0, 32'h89ABCDEF, "lx0");
      run_op(1, 0, 3'b010, 32'h300, 0, 5'd7, 0, 20, 32'h0, "ldtmo");
      run_op(0, 1, 3'b010, 32'h300, 32'h5, 5'd0, 9, 0, 0, "sttmo");

      // Reset during WAIT, then a late rvalid.
      @(negedge clk);
      valid = 1; ld = 1; st = 0; funct3 = 3'b010; addr = 32'h400; rd_in = 5'd9;
      @(negedge clk); valid = 0; gnt = 1;
      @(negedge clk); gnt = 0;
      chk("wait_busy", 32'(busy), 1);
      #1 rst_n = 0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_req", 32'(bus_req), 0);
      chk("arst_addr", bus_addr, 0);
      chk("arst_be", 32'(bus_be), 0);
      chk("arst_rd", 32'(rd_addr), 0);
      @(negedge clk); rst_n = 1;
      rvalid = 1; rdata = 32'h11111111;
      @(negedge clk); rvalid = 0;
      chk("late_rd", 32'(rd_addr), 0);
      chk("late_busy", 32'(busy), 0);

      for (int i = 0; i < 300; i++) begin
         kind = int'($urandom_range(0, 9));
         l = (kind == 0) || (kind >= 1 && kind <= 5);
         s = (kind == 0) || (kind >= 6);
         f = 3'($urandom);
         a = $urandom;
         if ($urandom_range(0, 9) < 7) begin
            if (f[1:0] == 2'd1) a[0] = 1'b0;
            if (f[1:0] == 2'd2) a[1:0] = 2'b00;
            if (f[1:0] == 2'd3) f[1:0] = 2'd2;
            if (s) f[2] = 1'b0;
            if (f[1:0] == 2'd2) a[1:0] = 2'b00;
         end
         // Avoid an event landing exactly on the timeout cycle.
         do begin
            g = int'($urandom_range(0, 5));
            r = int'($urandom_range(0, 4));
         end while ((l ? g + 1 + r : g) == T);
         run_op(l, s, f, a, $urandom, 5'($urandom), g, r, $urandom, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
